srrc_feed_ctrl: RTL and testbench

Sequences the input side of srrc_filter. Buffers incoming symbols in a small FIFO and generates the sample-rate enable strobe. Upsamples by OSR through zero-stuffing and drives the filter's 18-bit signed x_in. Sits between the symbol source (mapper or bench) and srrc_filter.

---
 rtl/srrc_pkg.sv | 21 ++
 rtl/srrc_sym_fifo.sv | 65 ++++++
 rtl/srrc_feed_ctrl.sv | 174 +++++++++++++++++
 tb/tb_srrc_feed_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srrc_pkg.sv
// Shared constants and types for the srrc filter input path.
package srrc_pkg;

  localparam int DATA_W     = 18;
  localparam int OSR        = 4;
  localparam int IMP_PERIOD = 21;

  typedef logic signed [DATA_W-1:0] sample_t;

  localparam sample_t IMP_AMP = 18'sd131071;

  // What a sample slot writes to x_out
  typedef enum logic [2:0] {
    SLOT_HOLD,     // no tick: x_out keeps its value
    SLOT_SYMBOL,   // phase 0 with data: pop head onto x_out
    SLOT_ZERO,     // stuffed zero
    SLOT_STARVED,  // phase 0 with empty FIFO: zero and flag underrun
    SLOT_IMPULSE   // impulse test peak
  } slot_e;

endpackage

// File: rtl/srrc_sym_fifo.sv
// Symbol FIFO: synchronous, power-of-two depth, no write-to-read bypass.
module srrc_sym_fifo #(
  parameter  int DATA_W = 18,
  parameter  int DEPTH  = 4,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     count;
  logic              do_wr;
  logic              do_rd;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = push && !full;
  assign do_rd = pop && !empty;
  assign dout  = mem[rd_ptr];
  assign level = count;

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_rd) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/srrc_feed_ctrl.sv
// Input sequencer for srrc_filter: symbol FIFO, sample-rate strobe and
// OSR zero-stuffing onto x_out.
// Optional impulse test source enabled by SRRC_IMPULSE_TEST_EN.
module srrc_feed_ctrl #(
  parameter int DATA_W     = srrc_pkg::DATA_W,
  parameter int OSR        = srrc_pkg::OSR,
  parameter int SAMP_DIV   = 4,
  parameter int FIFO_DEPTH = 4
`ifdef SRRC_IMPULSE_TEST_EN
  ,
  parameter int IMP_PERIOD = srrc_pkg::IMP_PERIOD
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic signed [DATA_W-1:0]      sym_in,
  input  logic                          sym_valid,
  output logic                          sym_ready,
  output logic signed [DATA_W-1:0]      x_out,
  output logic                          samp_en,
  output logic [$clog2(OSR)-1:0]        phase,
  output logic                          underrun,
  input  logic                          clr_underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef SRRC_IMPULSE_TEST_EN
  ,
  input  logic                          test_mode
`endif
);

  import srrc_pkg::*;

  localparam int PH_W  = $clog2(OSR);
  localparam int DIV_W = (SAMP_DIV > 1) ? $clog2(SAMP_DIV) : 1;

  logic [DIV_W-1:0]  div;
  logic [PH_W-1:0]   slot;
  logic              alive;
  logic              tick;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] head;
  slot_e             slot_kind;

  assign tick      = en && (div == DIV_W'(SAMP_DIV - 1));
  assign sym_ready = alive && !fifo_full;
  assign push      = sym_valid && sym_ready;
  assign pop       = (slot_kind == SLOT_SYMBOL);

  srrc_sym_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (sym_in),
    .dout  (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Accept symbols only from the first clock after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  // Sample-rate divider, held at zero while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (!en || tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

`ifdef SRRC_IMPULSE_TEST_EN
  localparam int IMP_W = (IMP_PERIOD > 1) ? $clog2(IMP_PERIOD) : 1;
  logic [IMP_W-1:0] imp_cnt;

  // Impulse period counter, counts ticks only while test mode runs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imp_cnt <= '0;
    end else if (!en || !test_mode) begin
      imp_cnt <= '0;
    end else if (tick) begin
      imp_cnt <= (imp_cnt == IMP_W'(IMP_PERIOD - 1)) ? '0 : imp_cnt + IMP_W'(1);
    end
  end
`endif

  // Classify the current tick; slot is the phase this tick will carry
  always_comb begin
    slot_kind = SLOT_HOLD;
    if (tick) begin
`ifdef SRRC_IMPULSE_TEST_EN
      if (test_mode) begin
        slot_kind = (imp_cnt == '0) ? SLOT_IMPULSE : SLOT_ZERO;
      end else
`endif
      if (slot != '0) begin
        slot_kind = SLOT_ZERO;
      end else if (fifo_empty) begin
        slot_kind = SLOT_STARVED;
      end else begin
        slot_kind = SLOT_SYMBOL;
      end
    end
  end

  // Phase tracking: slot runs one step ahead of the published phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot  <= '0;
      phase <= '0;
    end else if (!en) begin
      slot  <= '0;
      phase <= '0;
    end else if (tick) begin
      phase <= slot;
      slot  <= (slot == PH_W'(OSR - 1)) ? '0 : slot + PH_W'(1);
    end
  end

  // Sample strobe marks the cycle after a tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_en <= 1'b0;
    end else begin
      samp_en <= tick;
    end
  end

  // Output sample register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_out <= '0;
    end else if (!en) begin
      x_out <= '0;
    end else begin
      case (slot_kind)
        SLOT_SYMBOL:  x_out <= $signed(head);
        SLOT_IMPULSE: x_out <= DATA_W'(IMP_AMP);
        SLOT_ZERO:    x_out <= '0;
        SLOT_STARVED: x_out <= '0;
        default:      x_out <= x_out;
      endcase
    end
  end

  // Sticky underrun flag; a new underrun beats a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underrun <= 1'b0;
    end else if (slot_kind == SLOT_STARVED) begin
      underrun <= 1'b1;
    end else if (clr_underrun) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_srrc_feed_ctrl.sv
// Self-checking bench for srrc_feed_ctrl (default build).
module tb_srrc_feed_ctrl;

  localparam int DATA_W   = 18;
  localparam int OSR      = 4;
  localparam int SAMP_DIV = 4;
  localparam int DEPTH    = 4;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic                        en = 1'b0;
  logic signed [DATA_W-1:0]    sym_in = '0;
  logic                        sym_valid = 1'b0;
  logic                        clr_underrun = 1'b0;
  logic                        sym_ready;
  logic signed [DATA_W-1:0]    x_out;
  logic                        samp_en;
  logic [$clog2(OSR)-1:0]      phase;
  logic                        underrun;
  logic [$clog2(DEPTH):0]      fifo_level;
`ifdef SRRC_IMPULSE_TEST_EN
  logic                        test_mode = 1'b0;
`endif

  srrc_feed_ctrl #(
    .DATA_W     (DATA_W),
    .OSR        (OSR),
    .SAMP_DIV   (SAMP_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .sym_in       (sym_in),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .x_out        (x_out),
    .samp_en      (samp_en),
    .phase        (phase),
    .underrun     (underrun),
    .clr_underrun (clr_underrun),
`ifdef SRRC_IMPULSE_TEST_EN
    .test_mode    (test_mode),
`endif
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_q[$];
  bit  m_alive = 0;
  int  m_div = 0;
  int  m_next_phase = 0;
  int  m_phase = 0;
  int  m_x = 0;
  bit  m_samp = 0;
  bit  m_und = 0;

  task automatic model_reset();
    m_q.delete();
    m_alive = 0; m_div = 0; m_next_phase = 0; m_phase = 0;
    m_x = 0; m_samp = 0; m_und = 0;
  endtask

  task automatic model_step();
    bit ready, tick, starved, take;
    int incoming;
    ready    = m_alive && (m_q.size() < DEPTH);
    take     = sym_valid && ready;
    incoming = int'(sym_in);
    tick     = en && (m_div == SAMP_DIV - 1);
    starved  = 0;
    if (!en) begin
      m_div = 0; m_next_phase = 0; m_phase = 0; m_x = 0; m_samp = 0;
    end else begin
      m_samp = tick;
      if (tick) begin
        m_phase = m_next_phase;
        if (m_next_phase != 0) m_x = 0;
        else if (m_q.size() == 0) begin m_x = 0; starved = 1; end
        else m_x = m_q.pop_front();
        m_next_phase = (m_next_phase + 1) % OSR;
        m_div = 0;
      end else begin
        m_div = m_div + 1;
      end
    end
    if (take) m_q.push_back(incoming);
    if (starved) m_und = 1;
    else if (clr_underrun) m_und = 0;
    m_alive = 1;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle comparison ----------------
  bit cap_on = 0;
  int cap_x[$];
  int cap_ph[$];
  int cap_t[$];
  int cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      check("x_out",      int'(x_out),      m_x);
      check("samp_en",    int'(samp_en),    int'(m_samp));
      check("phase",      int'(phase),      m_phase);
      check("underrun",   int'(underrun),   int'(m_und));
      check("fifo_level", int'(fifo_level), m_q.size());
      check("sym_ready",  int'(sym_ready),  int'(m_alive && (m_q.size() < DEPTH)));
      if (cap_on && samp_en) begin
        cap_x.push_back(int'(x_out));
        cap_ph.push_back(int'(phase));
        cap_t.push_back(cyc);
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_sym(input int v);
    sym_valid = 1'b1;
    sym_in    = DATA_W'(v);
    step();
    sym_valid = 1'b0;
  endtask

  task automatic wait_model_empty(input string name);
    int k;
    k = 0;
    while (m_q.size() != 0 && k < 300) begin step(); k++; end
    check(name, m_q.size(), 0);
  endtask

  int exp_zs[12] = '{100, 0, 0, 0, -200, 0, 0, 0, 300, 0, 0, 0};

  initial begin
    int k;
    int zeros;
    bit seen;
    int p0[$];

    // Reset / idle
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_sym_ready", int'(sym_ready), 0);
    check("rst_x_out", int'(x_out), 0);
    check("rst_samp_en", int'(samp_en), 0);
    check("rst_level", int'(fifo_level), 0);
    #33 reset = 1'b1;
    step();
    @(negedge clk);
    check("rel_sym_ready", int'(sym_ready), 1);
    check("rel_level", int'(fifo_level), 0);
    step();

    // Zero-stuffing
    push_sym(100);
    push_sym(-200);
    push_sym(300);
    check("zs_level3", int'(fifo_level), 3);
    cap_x.delete(); cap_ph.delete(); cap_t.delete();
    cap_on = 1;
    en = 1'b1;
    k = 0;
    while (cap_x.size() < 12 && k < 200) begin step(); k++; end
    cap_on = 0;
    if (cap_x.size() < 12) begin
      check("zs_timeout", cap_x.size(), 12);
    end else begin
      for (int i = 0; i < 12; i++) begin
        check("zs_x", cap_x[i], exp_zs[i]);
        check("zs_phase", cap_ph[i], i % OSR);
        if (i > 0) check("zs_period", cap_t[i] - cap_t[i-1], SAMP_DIV);
      end
    end

    // Underrun and set-beats-clear
    k = 0;
    while (!m_und && k < 100) begin step(); k++; end
    check("und_set", int'(underrun), 1);
    k = 0;
    while (!(m_div == SAMP_DIV - 1 && m_next_phase == 0) && k < 100) begin step(); k++; end
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    check("und_clr_vs_set", int'(underrun), 1);
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    check("und_clr", int'(underrun), 0);
    en = 1'b0;
    step();

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      sym_valid = 1'b1;
      sym_in    = DATA_W'(1000 + i);
      if (i == 4) check("bp_ready_5th", int'(sym_ready), 0);
      step();
    end
    sym_valid = 1'b0;
    check("bp_level", int'(fifo_level), 4);
    check("bp_ready", int'(sym_ready), 0);
    en = 1'b1;
    zeros = 0;
    seen  = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (sym_ready) seen = 1;
      else zeros++;
    end
    check("bp_ready_return", int'(seen), 1);
    check("bp_ready_latency", zeros, 4);
    step();
    wait_model_empty("bp_drain");
    en = 1'b0;
    step();

    // en toggle mid-symbol
    push_sym(11);
    push_sym(22);
    push_sym(33);
    en = 1'b1;
    k = 0;
    while (!(m_samp && m_phase == 2) && k < 100) begin step(); k++; end
    check("tog_reach_ph2", int'(phase), 2);
    en = 1'b0;
    step();
    check("tog_phase", int'(phase), 0);
    check("tog_x", int'(x_out), 0);
    check("tog_samp", int'(samp_en), 0);
    cap_x.delete(); cap_ph.delete(); cap_t.delete();
    cap_on = 1;
    en = 1'b1;
    k = 0;
    p0.delete();
    while (p0.size() < 2 && k < 200) begin
      step(); k++;
      p0.delete();
      foreach (cap_x[i]) if (cap_ph[i] == 0) p0.push_back(cap_x[i]);
    end
    cap_on = 0;
    if (p0.size() < 2) begin
      check("tog_timeout", p0.size(), 2);
    end else begin
      check("tog_first_phase", cap_ph[0], 0);
      check("tog_sym0", p0[0], 22);
      check("tog_sym1", p0[1], 33);
    end

    // Randomized traffic
    en = 1'b1;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 59) == 0) en = ~en;
      if (i < 450) sym_valid = ($urandom_range(0, 7) < 2);
      else         sym_valid = ($urandom_range(0, 19) == 0);
      sym_in       = DATA_W'($urandom);
      clr_underrun = ($urandom_range(0, 11) == 0);
      if (i == 600) begin
        reset = 1'b0;
        #1 reset = 1'b1;
      end
      step();
    end
    sym_valid = 1'b0;
    clr_underrun = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Run-time bound
  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
